// File: rtl/death_ctrl.sv
// Kid death/restart sequencer: ALIVE -> DYING (flashing) -> DEAD (game over) -> RESPAWN (level_rst pulse).
// It also keeps a saturating death counter for the HUD.
module death_ctrl #(
    parameter int N_TRAPS      = 8,
    parameter int DYING_FRAMES = 32,
    parameter int FLASH_PERIOD = 4,
    parameter int RESPAWN_HOLD = 2,
    parameter int MAX_DEATHS   = 999
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               frame_tick,
    input  logic [N_TRAPS-1:0] collide,
    input  logic               kid_fell,
    input  logic               restart_key,
    output logic               kid_alive,
    output logic               freeze,
    output logic               flash_on,
    output logic               show_gameover,
    output logic               level_rst,
    output logic [9:0]         death_count,
    output logic [1:0]         state
);

    localparam logic [1:0] ST_ALIVE   = 2'd0;
    localparam logic [1:0] ST_DYING   = 2'd1;
    localparam logic [1:0] ST_DEAD    = 2'd2;
    localparam logic [1:0] ST_RESPAWN = 2'd3;

    localparam int FRAME_W = $clog2(DYING_FRAMES + 1);
    localparam int FLASH_W = $clog2(FLASH_PERIOD + 1);
    localparam int HOLD_W  = $clog2(RESPAWN_HOLD + 1);

    logic [1:0]         state_reg, state_next;
    logic [FRAME_W-1:0] frame_cnt_reg, frame_cnt_next;
    logic [FLASH_W-1:0] flash_phase_reg, flash_phase_next;
    logic [HOLD_W-1:0]  hold_cnt_reg, hold_cnt_next;
    logic               flash_reg, flash_next;
    logic [9:0]         count_reg, count_next;
    logic               key_prev_reg;
    logic               first_alive_reg, first_alive_next;

    logic               kid_alive_reg, freeze_reg, flash_on_reg;
    logic               show_gameover_reg, level_rst_reg;

    logic               key_edge;
    logic               mask;
    logic               hit;
    logic [FRAME_W-1:0] frame_inc;
    logic [FLASH_W-1:0] flash_phase_inc;

    assign key_edge        = restart_key & ~key_prev_reg;
    // Hits are blanked while the level is being reset and for one cycle after, so
    // traps still sitting on the kid's spawn point cannot kill him immediately.
    assign mask            = (state_reg == ST_RESPAWN) | first_alive_reg;
    assign hit             = ((|collide) | kid_fell) & ~mask;
    assign frame_inc       = frame_cnt_reg + FRAME_W'(1);
    assign flash_phase_inc = flash_phase_reg + FLASH_W'(1);

    always_comb begin
        state_next       = state_reg;
        frame_cnt_next   = frame_cnt_reg;
        flash_phase_next = flash_phase_reg;
        hold_cnt_next    = hold_cnt_reg;
        flash_next       = flash_reg;
        count_next       = count_reg;
        first_alive_next = 1'b0;

        case (state_reg)
            ST_ALIVE: begin
                if (hit) begin
                    state_next       = ST_DYING;
                    frame_cnt_next   = '0;
                    flash_phase_next = '0;
                    flash_next       = 1'b1;
                    if (count_reg != 10'(MAX_DEATHS)) begin
                        count_next = count_reg + 10'd1;
                    end
                end else if (key_edge) begin
                    state_next    = ST_RESPAWN;
                    hold_cnt_next = '0;
                end
            end
            ST_DYING: begin
                if (key_edge) begin
                    state_next    = ST_RESPAWN;
                    hold_cnt_next = '0;
                end else if (frame_tick) begin
                    frame_cnt_next = frame_inc;
                    if (frame_inc == FRAME_W'(DYING_FRAMES)) begin
                        state_next = ST_DEAD;
                    end else if (flash_phase_inc == FLASH_W'(FLASH_PERIOD)) begin
                        flash_phase_next = '0;
                        flash_next       = ~flash_reg;
                    end else begin
                        flash_phase_next = flash_phase_inc;
                    end
                end
            end
            ST_DEAD: begin
                if (key_edge) begin
                    state_next    = ST_RESPAWN;
                    hold_cnt_next = '0;
                end
            end
            default: begin
                // The restart key is deliberately ignored here; the hold always runs to completion.
                if (hold_cnt_reg == HOLD_W'(RESPAWN_HOLD - 1)) begin
                    state_next       = ST_ALIVE;
                    frame_cnt_next   = '0;
                    first_alive_next = 1'b1;
                end else begin
                    hold_cnt_next = hold_cnt_reg + HOLD_W'(1);
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg         <= ST_ALIVE;
            frame_cnt_reg     <= '0;
            flash_phase_reg   <= '0;
            hold_cnt_reg      <= '0;
            flash_reg         <= 1'b0;
            count_reg         <= '0;
            key_prev_reg      <= 1'b0;
            first_alive_reg   <= 1'b0;
            kid_alive_reg     <= 1'b1;
            freeze_reg        <= 1'b0;
            flash_on_reg      <= 1'b0;
            show_gameover_reg <= 1'b0;
            level_rst_reg     <= 1'b0;
        end else begin
            state_reg         <= state_next;
            frame_cnt_reg     <= frame_cnt_next;
            flash_phase_reg   <= flash_phase_next;
            hold_cnt_reg      <= hold_cnt_next;
            flash_reg         <= flash_next;
            count_reg         <= count_next;
            key_prev_reg      <= restart_key;
            first_alive_reg   <= first_alive_next;
            kid_alive_reg     <= (state_next == ST_ALIVE);
            freeze_reg        <= (state_next != ST_ALIVE);
            flash_on_reg      <= (state_next == ST_DYING) & flash_next;
            show_gameover_reg <= (state_next == ST_DEAD);
            level_rst_reg     <= (state_next == ST_RESPAWN);
        end
    end

    assign kid_alive     = kid_alive_reg;
    assign freeze        = freeze_reg;
    assign flash_on      = flash_on_reg;
    assign show_gameover = show_gameover_reg;
    assign level_rst     = level_rst_reg;
    assign death_count   = count_reg;
    assign state         = state_reg;

endmodule

// File: tb/tb_death_ctrl.sv
// Bench for death_ctrl: directed scenarios followed by random traffic, all checked every cycle
// against a rule-level model of the death/restart sequence.
module tb_death_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       frame_tick = 1'b0;
    logic [7:0] collide = 8'h00;
    logic       kid_fell = 1'b0;
    logic       restart_key = 1'b0;
    logic       kid_alive, freeze, flash_on, show_gameover, level_rst;
    logic [9:0] death_count;
    logic [1:0] state;

    int checks = 0;
    int failures = 0;

    // Reference model: phase 0 alive, 1 dying, 2 dead, 3 respawn.
    int m_phase = 0;
    int m_ticks = 0;
    int m_rst_cycles = 0;
    int m_flash = 0;
    int m_deaths = 0;
    int m_key_prev = 0;
    int m_grace = 0;

    always #5 clk = ~clk;

    death_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .frame_tick    (frame_tick),
        .collide       (collide),
        .kid_fell      (kid_fell),
        .restart_key   (restart_key),
        .kid_alive     (kid_alive),
        .freeze        (freeze),
        .flash_on      (flash_on),
        .show_gameover (show_gameover),
        .level_rst     (level_rst),
        .death_count   (death_count),
        .state         (state)
    );

    task automatic chk(input string tag, input int observed, input int expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic model_edge();
        int pressed;
        int blanked;
        int died;
        if (rst) begin
            m_phase = 0; m_ticks = 0; m_rst_cycles = 0; m_flash = 0;
            m_deaths = 0; m_key_prev = 0; m_grace = 0;
            return;
        end
        pressed = (restart_key && !m_key_prev) ? 1 : 0;
        m_key_prev = int'(restart_key);
        blanked = (m_phase == 3 || m_grace != 0) ? 1 : 0;
        died = ((collide != 0 || kid_fell) && blanked == 0) ? 1 : 0;
        m_grace = 0;
        if (m_phase == 0) begin
            if (died != 0) begin
                m_phase = 1; m_ticks = 0; m_flash = 1;
                m_deaths = (m_deaths < 999) ? m_deaths + 1 : 999;
            end else if (pressed != 0) begin
                m_phase = 3; m_rst_cycles = 0;
            end
        end else if (m_phase == 1) begin
            if (pressed != 0) begin
                m_phase = 3; m_rst_cycles = 0;
            end else if (frame_tick) begin
                m_ticks++;
                if (m_ticks == 32) m_phase = 2;
                else if (m_ticks % 4 == 0) m_flash = 1 - m_flash;
            end
        end else if (m_phase == 2) begin
            if (pressed != 0) begin
                m_phase = 3; m_rst_cycles = 0;
            end
        end else begin
            m_rst_cycles++;
            if (m_rst_cycles == 2) begin
                m_phase = 0; m_grace = 1; m_ticks = 0;
            end
        end
    endtask

    task automatic check_all();
        chk("state", int'(state), m_phase);
        chk("kid_alive", int'(kid_alive), (m_phase == 0) ? 1 : 0);
        chk("freeze", int'(freeze), (m_phase != 0) ? 1 : 0);
        chk("flash_on", int'(flash_on), (m_phase == 1) ? m_flash : 0);
        chk("show_gameover", int'(show_gameover), (m_phase == 2) ? 1 : 0);
        chk("level_rst", int'(level_rst), (m_phase == 3) ? 1 : 0);
        chk("death_count", int'(death_count), m_deaths);
    endtask

    task automatic drive(input logic [7:0] c, input logic f, input logic k,
                         input logic t, input logic r);
        collide = c; kid_fell = f; restart_key = k; frame_tick = t; rst = r;
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    initial begin
        int lvl_cycles;

        // Reset for three cycles
        for (int i = 0; i < 3; i++) drive(8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("reset_state", int'(state), 0);
        chk("reset_alive", int'(kid_alive), 1);
        chk("reset_lvl", int'(level_rst), 0);
        chk("reset_count", int'(death_count), 0);
        drive(8'h00, 1'b0, 1'b0, 1'b0, 1'b0);

        // Single-cycle collide on trap 3
        drive(8'h08, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("hit_state", int'(state), 1);
        chk("hit_freeze", int'(freeze), 1);
        chk("hit_count", int'(death_count), 1);

        // 32 frame ticks through the dying animation
        for (int i = 1; i <= 32; i++) begin
            drive(8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
            if (i < 32) chk("dying_flash", int'(flash_on), ((i / 4) % 2 == 0) ? 1 : 0);
            drive(8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        chk("dead_state", int'(state), 2);
        chk("dead_gameover", int'(show_gameover), 1);

        // Restart from DEAD with collide held through the blanked window
        lvl_cycles = 0;
        drive(8'hFF, 1'b0, 1'b1, 1'b0, 1'b0);
        lvl_cycles += int'(level_rst);
        for (int i = 0; i < 3; i++) begin
            drive(8'hFF, 1'b0, 1'b0, 1'b0, 1'b0);
            lvl_cycles += int'(level_rst);
        end
        chk("respawn_len", lvl_cycles, 2);
        chk("respawn_state", int'(state), 0);
        chk("respawn_count", int'(death_count), 1);

        // Fall and restart key together: the death wins
        drive(8'h00, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("both_state", int'(state), 1);
        chk("both_count", int'(death_count), 2);
        drive(8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("skip_anim", int'(state), 3);
        for (int i = 0; i < 4; i++) drive(8'h00, 1'b0, 1'b0, 1'b0, 1'b0);

        // Voluntary restart keeps the count
        drive(8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("vol_state", int'(state), 3);
        chk("vol_count", int'(death_count), 2);

        // Key held across RESPAWN->ALIVE must not trigger a second restart
        for (int i = 0; i < 6; i++) drive(8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("held_key", int'(state), 0);
        drive(8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("repress", int'(state), 3);
        for (int i = 0; i < 4; i++) drive(8'h00, 1'b0, 1'b0, 1'b0, 1'b0);

        // Die repeatedly until the counter saturates, then once more
        for (int i = 0; i < 1000; i++) begin
            drive(8'h01 << (i % 8), 1'b0, 1'b0, 1'b0, 1'b0);
            drive(8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
            drive(8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
            drive(8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
            drive(8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        chk("sat_count", int'(death_count), 999);
        drive(8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("sat_dying", int'(state), 1);
        chk("sat_hold", int'(death_count), 999);

        // Reset in the middle of DYING
        drive(8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
        drive(8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("abort_state", int'(state), 0);
        chk("abort_alive", int'(kid_alive), 1);
        chk("abort_freeze", int'(freeze), 0);
        chk("abort_flash", int'(flash_on), 0);
        chk("abort_lvl", int'(level_rst), 0);
        chk("abort_count", int'(death_count), 0);

        // Random traffic
        for (int i = 0; i < 4000; i++) begin
            logic [7:0] c;
            logic f, k, t, r;
            c = ($urandom_range(0, 19) == 0) ? 8'($urandom) : 8'h00;
            f = ($urandom_range(0, 29) == 0);
            k = ($urandom_range(0, 7) == 0) ? ~restart_key : restart_key;
            t = ($urandom_range(0, 2) == 0);
            r = ($urandom_range(0, 299) == 0);
            drive(c, f, k, t, r);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
